// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: select sequencer for a 4:1 mux stage.
// Walks the enabled channels in ascending order, holding each select for
// DWELL cycles, samples the mux output on the last dwell cycle of each
// channel and publishes the collected bits as a 4-bit snapshot.
//
// Handshake: start is a level qualifier sampled only while idle (busy=0);
// done and sample_stb are single-cycle pulses with no back-pressure, and
// the consumer must take scan_data on the cycle done is high or later
// (scan_data holds until the next completed scan).
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] ch_en,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic [3:0] scan_data,
  output logic       busy,
  output logic       done,
  output logic       sample_stb
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Last dwell count before the sample edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       en_q, en_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       scan_data_q, scan_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_stb_q, sample_stb_d;

  logic [2:0] next_info;
  logic       at_sample;
  logic       completing;
  logic [3:0] merged;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above s.
  function automatic logic [2:0] next_bit(input logic [3:0] m, input logic [1:0] s);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Helper terms for the scan step: where the walk goes next and the
  // snapshot with the bit being sampled this cycle folded in.
  always_comb begin
    next_info       = next_bit(en_q, sel_q);
    at_sample       = (cnt_q == CNT_LAST);
    completing      = at_sample && !next_info[2];
    merged          = shadow_q;
    merged[sel_q]   = mux_y;
  end

  // Next-state logic for the IDLE/SCAN sequencer.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    shadow_d     = shadow_q;
    scan_data_d  = scan_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sample_stb_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop beats start; an empty mask completes at once with zero data.
        if (start && !stop) begin
          if (ch_en == 4'b0000) begin
            scan_data_d = 4'b0000;
            done_d      = 1'b1;
          end else begin
            en_d     = ch_en;
            shadow_d = 4'b0000;
            sel_d    = lowest_bit(ch_en);
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = ST_SCAN;
          end
        end
      end

      default: begin
        if (stop && !completing) begin
          // Abort: partial snapshot is dropped, published data untouched.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (at_sample) begin
          shadow_d     = merged;
          sample_stb_d = 1'b1;
          cnt_d        = '0;
          if (next_info[2]) begin
            sel_d = next_info[1:0];
          end else begin
            // Scan complete; completion wins over a coincident stop.
            scan_data_d = merged;
            done_d      = 1'b1;
            if (mode && !stop && (ch_en != 4'b0000)) begin
              en_d     = ch_en;
              shadow_d = 4'b0000;
              sel_d    = lowest_bit(ch_en);
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              sel_d   = 2'd0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and output registers; reset drops any partial scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      cnt_q        <= '0;
      en_q         <= 4'b0000;
      shadow_q     <= 4'b0000;
      scan_data_q  <= 4'b0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      shadow_q     <= shadow_d;
      scan_data_q  <= scan_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  assign sel        = sel_q;
  assign scan_data  = scan_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_stb = sample_stb_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: vector table of single scans, hand-written
// sequences for continuous mode, abort, reset and start-while-busy, and a
// randomized phase checked cycle by cycle against a timeline model.
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] ch_en;
  logic [3:0] mux_in;
  logic       mux_y;
  logic [1:0] sel;
  logic [3:0] scan_data;
  logic       busy;
  logic       done;
  logic       sample_stb;

  int n_checks = 0;
  int n_fail   = 0;

  // The mux stage being sequenced.
  assign mux_y = mux_in[sel];

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .ch_en      (ch_en),
    .mux_y      (mux_y),
    .sel        (sel),
    .scan_data  (scan_data),
    .busy       (busy),
    .done       (done),
    .sample_stb (sample_stb)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (scan timeline) ----------------
  // A scan is a list of channels; elapsed cycle t maps to channel
  // chans[t / DWELL], and a sample happens on the last cycle of each slot.
  bit         m_scan;
  int         m_chans[$];
  int         m_t;
  logic [3:0] m_shadow;
  logic [1:0] m_sel;
  logic [3:0] m_data;
  logic       m_busy;
  logic       m_done;
  logic       m_stb;

  task automatic m_reset();
    m_scan = 0; m_chans.delete(); m_t = 0; m_shadow = '0;
    m_sel = '0; m_data = '0; m_busy = 0; m_done = 0; m_stb = 0;
  endtask

  task automatic m_begin(input logic [3:0] en);
    m_chans.delete();
    for (int i = 0; i < 4; i++) if (en[i]) m_chans.push_back(i);
    m_t = 0; m_shadow = '0; m_scan = 1; m_busy = 1;
    m_sel = 2'(m_chans[0]);
  endtask

  task automatic m_idle();
    m_scan = 0; m_busy = 0; m_sel = '0;
  endtask

  // One clock edge with the inputs currently applied.
  task automatic m_step();
    int  idx, ch;
    bit  smp, last;
    m_done = 0; m_stb = 0;
    if (!m_scan) begin
      if (start && !stop) begin
        if (ch_en == 4'b0000) begin
          m_data = '0; m_done = 1;
        end else begin
          m_begin(ch_en);
        end
      end
    end else begin
      idx  = m_t / DWELL;
      ch   = m_chans[idx];
      smp  = (m_t % DWELL) == DWELL - 1;
      last = smp && (idx == m_chans.size() - 1);
      if (stop && !last) begin
        m_idle();
      end else begin
        m_t++;
        if (smp) begin
          m_shadow[ch] = mux_in[ch];
          m_stb = 1;
        end
        if (last) begin
          m_data = m_shadow; m_done = 1;
          if (mode && !stop && ch_en != 4'b0000) m_begin(ch_en);
          else m_idle();
        end else begin
          m_sel = 2'(m_chans[m_t / DWELL]);
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, step the model, and compare every output.
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check("cycle_outputs {sel,data,busy,done,stb}",
          {23'd0, sel, scan_data, busy, done, sample_stb},
          {23'd0, m_sel, m_data, m_busy, m_done, m_stb});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    logic [3:0] ch_en;
    logic [3:0] mux_in;
    logic [3:0] exp_data;
    int         exp_edges;
    int         exp_stb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, stbs, done_at, done_cnt;
    logic [3:0] d16, d32;

    vecs[0] = '{1'b0, 4'b1111, 4'b1010, 4'b1010, 16, 4};
    vecs[1] = '{1'b0, 4'b0101, 4'b1111, 4'b0101,  8, 2};
    vecs[2] = '{1'b0, 4'b0000, 4'b1111, 4'b0000,  0, 0};
    vecs[3] = '{1'b0, 4'b1000, 4'b1000, 4'b1000,  4, 1};
    vecs[4] = '{1'b0, 4'b0110, 4'b0100, 4'b0100,  8, 2};
    vecs[5] = '{1'b0, 4'b1011, 4'b0001, 4'b0001, 12, 3};

    // Clock/reset
    rst = 1'b1; start = 0; stop = 0; mode = 0; ch_en = '0; mux_in = '0;
    m_reset();
    #12;
    check("reset_outputs", {23'd0, sel, scan_data, busy, done, sample_stb}, 32'd0);
    rst = 1'b0;

    // Table-driven single scans
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode; ch_en = vecs[v].ch_en; mux_in = vecs[v].mux_in;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; stbs = 0;
      while (!done && n < 100) begin
        tick();
        n++;
        stbs += int'(sample_stb);
      end
      check($sformatf("vec%0d_done_edge", v), n, vecs[v].exp_edges);
      check($sformatf("vec%0d_scan_data", v), {28'd0, scan_data}, {28'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_stb_count", v), stbs, vecs[v].exp_stb);
      check($sformatf("vec%0d_busy_after", v), {31'd0, busy}, 32'd0);
      tick(); tick();
    end

    // Continuous scan, input change at edge 18, abort at edge 36
    mode = 1; ch_en = 4'b1111; mux_in = 4'b0011; start = 1;
    tick();
    start = 0;
    done_cnt = 0; d16 = 'x; d32 = 'x;
    for (int e = 1; e <= 40; e++) begin
      if (e == 18) mux_in = 4'b1100;
      stop = (e == 36);
      tick();
      if (done) begin
        done_cnt++;
        if (e == 16) d16 = scan_data;
        if (e == 32) d32 = scan_data;
      end
      if (e == 36) check("cont_busy_after_stop", {31'd0, busy}, 32'd0);
    end
    stop = 0;
    check("cont_done_count", done_cnt, 2);
    check("cont_data_16", {28'd0, d16}, 32'h3);
    check("cont_data_32", {28'd0, d32}, 32'hc);
    check("cont_data_kept", {28'd0, scan_data}, 32'hc);

    // stop coinciding with completion: completion wins, then idle
    mode = 1; ch_en = 4'b0001; mux_in = 4'b0001; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    stop = 1;
    tick();
    stop = 0;
    check("stop_at_done_pulse", {31'd0, done}, 32'd1);
    check("stop_at_done_data", {28'd0, scan_data}, 32'h1);
    check("stop_at_done_busy", {31'd0, busy}, 32'd0);
    tick();
    mode = 0;

    // start while busy is ignored: done still arrives 16 edges after start
    ch_en = 4'b1111; mux_in = 4'b0110; start = 1;
    tick();
    start = 0;
    done_at = -1;
    for (int e = 1; e <= 20; e++) begin
      start = (e == 5 || e == 9);
      tick();
      if (done && done_at < 0) done_at = e;
    end
    start = 0;
    check("busy_start_done_edge", done_at, 16);
    check("busy_start_data", {28'd0, scan_data}, 32'h6);

    // Asynchronous reset between edges mid-scan
    ch_en = 4'b1111; mux_in = 4'b1111; start = 1;
    tick();
    start = 0;
    for (int e = 0; e < 6; e++) tick();
    #3 rst = 1'b1;
    m_reset();
    #1;
    check("async_reset_outputs", {23'd0, sel, scan_data, busy, done, sample_stb}, 32'd0);
    #2 rst = 1'b0;
    tick(); tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 60) == 0);
      mode  = 1'($urandom_range(0, 1));
      ch_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0) mux_in = 4'($urandom_range(0, 15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
